// File: rtl/ahb_cmd_manager.sv
// AHB manager that turns a valid/ready command stream into pipelined single transfers.
// One address phase (A) and one data phase (D) in flight; an ERROR response aborts the queued A.
module ahb_cmd_manager #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic                 cmdWrite,
    input  logic [AddrWidth-1:0] cmdAddr,
    input  logic [DataWidth-1:0] cmdWData,
    output logic                 rspValid,
    output logic [DataWidth-1:0] rspRData,
    output logic                 rspError,
    output logic                 rspAbort,
    output logic [1:0]           trans,
    output logic [AddrWidth-1:0] addr,
    output logic                 write,
    output logic [DataWidth-1:0] wData,
    input  logic [DataWidth-1:0] rData,
    input  logic                 ready,
    input  logic                 resp
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    logic                 aValid_q, aValid_d;
    logic                 aWrite_q, aWrite_d;
    logic [AddrWidth-1:0] aAddr_q, aAddr_d;
    logic [DataWidth-1:0] aWData_q, aWData_d;
    logic                 dValid_q, dValid_d;
    logic                 dWrite_q, dWrite_d;
    logic [DataWidth-1:0] dWData_q, dWData_d;
    logic                 errHold_q, errHold_d;
    logic                 abortPend_q, abortPend_d;
    logic                 rspValid_q, rspValid_d;
    logic [DataWidth-1:0] rspRData_q, rspRData_d;
    logic                 rspError_q, rspError_d;
    logic                 rspAbort_q, rspAbort_d;

    logic busReady;
    logic errCycle1;
    logic phaseDone;
    logic advance;
    logic accept;

    // Bus ready only matters while a data phase is outstanding.
    assign busReady  = ~dValid_q | ready;
    assign errCycle1 = dValid_q & ~ready & resp;
    assign phaseDone = dValid_q & ready;
    assign advance   = busReady & ~errHold_q;
    assign cmdReady  = (~aValid_q | busReady) & ~abortPend_q & ~errHold_q;
    assign accept    = cmdValid & cmdReady;

    always_comb begin
        aValid_d    = aValid_q;
        aWrite_d    = aWrite_q;
        aAddr_d     = aAddr_q;
        aWData_d    = aWData_q;
        dValid_d    = dValid_q;
        dWrite_d    = dWrite_q;
        dWData_d    = dWData_q;
        errHold_d   = errHold_q;
        abortPend_d = abortPend_q;
        rspValid_d  = 1'b0;
        rspRData_d  = '0;
        rspError_d  = 1'b0;
        rspAbort_d  = 1'b0;

        if (phaseDone) begin
            rspValid_d = 1'b1;
            rspRData_d = dWrite_q ? '0 : rData;
            rspError_d = resp;
        end else if (abortPend_q && !dValid_q) begin
            // Abort response trails the failed transfer's response by one cycle.
            rspValid_d  = 1'b1;
            rspError_d  = 1'b1;
            rspAbort_d  = 1'b1;
            abortPend_d = 1'b0;
            errHold_d   = 1'b0;
        end

        if (advance) begin
            dValid_d = aValid_q;
            dWrite_d = aWrite_q;
            dWData_d = aWData_q;
            aValid_d = accept;
        end else begin
            if (phaseDone) begin
                dValid_d = 1'b0;
                if (!abortPend_q) begin
                    errHold_d = 1'b0;
                end
            end
            // First error cycle: cancel the queued address phase so the bus goes IDLE.
            if (errCycle1) begin
                errHold_d = 1'b1;
                if (aValid_q) begin
                    aValid_d    = 1'b0;
                    abortPend_d = 1'b1;
                end
            end
            if (accept) begin
                aValid_d = 1'b1;
            end
        end

        if (accept) begin
            aWrite_d = cmdWrite;
            aAddr_d  = cmdAddr;
            aWData_d = cmdWrite ? cmdWData : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aValid_q    <= 1'b0;
            aWrite_q    <= 1'b0;
            aAddr_q     <= '0;
            aWData_q    <= '0;
            dValid_q    <= 1'b0;
            dWrite_q    <= 1'b0;
            dWData_q    <= '0;
            errHold_q   <= 1'b0;
            abortPend_q <= 1'b0;
            rspValid_q  <= 1'b0;
            rspRData_q  <= '0;
            rspError_q  <= 1'b0;
            rspAbort_q  <= 1'b0;
        end else begin
            aValid_q    <= aValid_d;
            aWrite_q    <= aWrite_d;
            aAddr_q     <= aAddr_d;
            aWData_q    <= aWData_d;
            dValid_q    <= dValid_d;
            dWrite_q    <= dWrite_d;
            dWData_q    <= dWData_d;
            errHold_q   <= errHold_d;
            abortPend_q <= abortPend_d;
            rspValid_q  <= rspValid_d;
            rspRData_q  <= rspRData_d;
            rspError_q  <= rspError_d;
            rspAbort_q  <= rspAbort_d;
        end
    end

    assign trans    = aValid_q ? TransNonseq : TransIdle;
    assign addr     = aAddr_q;
    assign write    = aWrite_q;
    assign wData    = dWData_q;
    assign rspValid = rspValid_q;
    assign rspRData = rspRData_q;
    assign rspError = rspError_q;
    assign rspAbort = rspAbort_q;

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Bench for ahb_cmd_manager: directed commands against a small AHB subordinate model,
// with a response scoreboard and a log of address phases seen on the bus.
module tb_ahb_cmd_manager;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        abort;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdWrite = 1'b0;
    logic [31:0] cmdAddr = '0;
    logic [31:0] cmdWData = '0;
    logic        rspValid;
    logic [31:0] rspRData;
    logic        rspError;
    logic        rspAbort;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        ready;
    logic        resp;

    int checks = 0;
    int errors = 0;
    rsp_t expQ[$];
    logic [31:0] busLog[$];

    // Subordinate model controls: stall count for one address, and one erroring address.
    logic [31:0] waitAddr = 32'hFFFF_FFFF;
    int          waitPlan = 0;
    logic [31:0] errAddr  = 32'hFFFF_FFFF;
    logic        sValid = 1'b0;
    logic [31:0] sAddr = '0;
    logic        sWrite = 1'b0;
    logic        errStage = 1'b0;
    int          waitCnt = 0;
    logic        sErr;

    ahb_cmd_manager #(.AddrWidth(32), .DataWidth(32)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdWData(cmdWData),
        .rspValid(rspValid), .rspRData(rspRData), .rspError(rspError), .rspAbort(rspAbort),
        .trans(trans), .addr(addr), .write(write), .wData(wData),
        .rData(rData), .ready(ready), .resp(resp)
    );

    always #5 clk = ~clk;

    assign sErr = sValid && (sAddr == errAddr);

    always_comb begin
        ready = 1'b1;
        resp  = 1'b0;
        rData = '0;
        if (sValid) begin
            if (sErr) begin
                resp  = 1'b1;
                ready = errStage;
            end else begin
                ready = (waitCnt == 0);
                rData = sWrite ? (32'hBAD0_0000 | sAddr) : (32'h100 + sAddr);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            sValid   <= 1'b0;
            errStage <= 1'b0;
            waitCnt  <= 0;
        end else if (ready) begin
            sValid   <= (trans == 2'b10);
            sAddr    <= addr;
            sWrite   <= write;
            errStage <= 1'b0;
            waitCnt  <= (addr == waitAddr) ? waitPlan : 0;
        end else if (sErr) begin
            errStage <= 1'b1;
        end else begin
            waitCnt <= waitCnt - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds the command until accepted; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input bit expectRsp, input logic [31:0] expRData,
                                 input logic expErr, input logic expAbort);
        int guard = 0;
        bit ok;
        cmdValid = 1'b1;
        cmdWrite = w;
        cmdAddr  = a;
        cmdWData = d;
        if (expectRsp) expQ.push_back('{rdata: expRData, err: expErr, abort: expAbort});
        do begin
            ok = cmdReady;
            @(negedge clk);
            guard++;
        end while (!ok && guard < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout addr=0x%08h not accepted within 50 cycles", a);
        end
    endtask

    task automatic idleCmd();
        cmdValid = 1'b0;
        cmdWrite = 1'b0;
        cmdAddr  = '0;
        cmdWData = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && rspValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRsp rdata=0x%08h err=%0b abort=%0b", rspRData, rspError, rspAbort);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rspRData", rspRData, e.rdata);
                checkOutput("rspError", {31'b0, rspError}, {31'b0, e.err});
                checkOutput("rspAbort", {31'b0, rspAbort}, {31'b0, e.abort});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && trans == 2'b10 && ready) busLog.push_back(addr);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] expBus [14];
        expBus = '{32'h10, 32'h0, 32'h4, 32'h8, 32'hC, 32'h30, 32'h34, 32'h20,
                   32'h40, 32'h44, 32'h48, 32'h50, 32'h60, 32'h64};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetTrans", {30'b0, trans}, 32'h0);
        checkOutput("resetAddr", addr, 32'h0);
        checkOutput("resetWrite", {31'b0, write}, 32'h0);
        checkOutput("resetWData", wData, 32'h0);
        checkOutput("resetCmdReady", {31'b0, cmdReady}, 32'h1);
        checkOutput("resetRspValid", {31'b0, rspValid}, 32'h0);

        // Single zero-wait write.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 1'b0);
        idleCmd();
        checkOutput("wrTrans", {30'b0, trans}, 32'h2);
        checkOutput("wrAddr", addr, 32'h10);
        checkOutput("wrWrite", {31'b0, write}, 32'h1);
        @(negedge clk);
        checkOutput("wrWData", wData, 32'hDEADBEEF);
        checkOutput("wrRspEarly", {31'b0, rspValid}, 32'h0);
        @(negedge clk);
        checkOutput("wrRspLatency", {31'b0, rspValid}, 32'h1);
        repeat (2) @(negedge clk);

        // Four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'(4 * i), 32'h0, 1, 32'(32'h100 + 4 * i), 1'b0, 1'b0);
            checkOutput("b2bTrans", {30'b0, trans}, 32'h2);
            checkOutput("b2bAddr", addr, 32'(4 * i));
        end
        idleCmd();
        for (int k = 0; k < 3; k++) begin
            checkOutput("b2bRspPulse", {31'b0, rspValid}, 32'h1);
            @(negedge clk);
        end
        checkOutput("b2bRspEnd", {31'b0, rspValid}, 32'h0);
        repeat (2) @(negedge clk);

        // Read with three wait states; the following command must hold on the bus.
        waitAddr = 32'h30;
        waitPlan = 3;
        applyStimulus(1'b0, 32'h30, 32'h0, 1, 32'h130, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h34, 32'h0, 1, 32'h134, 1'b0, 1'b0);
        idleCmd();
        for (int k = 0; k < 3; k++) begin
            checkOutput("stallTrans", {30'b0, trans}, 32'h2);
            checkOutput("stallAddr", addr, 32'h34);
            checkOutput("stallCmdReady", {31'b0, cmdReady}, 32'h0);
            checkOutput("stallRsp", {31'b0, rspValid}, 32'h0);
            @(negedge clk);
        end
        checkOutput("stallRspLate", {31'b0, rspValid}, 32'h0);
        @(negedge clk);
        checkOutput("stallRspArrive", {31'b0, rspValid}, 32'h1);
        repeat (3) @(negedge clk);
        waitAddr = 32'hFFFF_FFFF;

        // Read 0x20 errors while write 0x24 waits in the address phase.
        errAddr = 32'h20;
        applyStimulus(1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h24, 32'h5555AAAA, 1, 32'h0, 1'b1, 1'b1);
        idleCmd();
        checkOutput("errAddrPhase", addr, 32'h24);
        @(negedge clk);
        checkOutput("errTransIdle", {30'b0, trans}, 32'h0);
        checkOutput("errCmdReadyE2", {31'b0, cmdReady}, 32'h0);
        @(negedge clk);
        checkOutput("errRsp1Abort", {31'b0, rspAbort}, 32'h0);
        checkOutput("errCmdReadyHold", {31'b0, cmdReady}, 32'h0);
        @(negedge clk);
        checkOutput("errRsp2Abort", {31'b0, rspAbort}, 32'h1);
        @(negedge clk);
        checkOutput("errRecoverReady", {31'b0, cmdReady}, 32'h1);
        checkOutput("errRecoverRsp", {31'b0, rspValid}, 32'h0);
        errAddr = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);

        // cmdValid held through a stall.
        waitAddr = 32'h40;
        waitPlan = 2;
        applyStimulus(1'b0, 32'h40, 32'h0, 1, 32'h140, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h44, 32'h0, 1, 32'h144, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h48, 32'h0, 1, 32'h148, 1'b0, 1'b0);
        idleCmd();
        repeat (6) @(negedge clk);
        waitAddr = 32'hFFFF_FFFF;

        // Reset during the data phase of a read drops it silently.
        applyStimulus(1'b0, 32'h50, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        idleCmd();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstTrans", {30'b0, trans}, 32'h0);
        checkOutput("midRstAddr", addr, 32'h0);
        checkOutput("midRstWrite", {31'b0, write}, 32'h0);
        checkOutput("midRstWData", wData, 32'h0);
        checkOutput("midRstRsp", {31'b0, rspValid}, 32'h0);
        checkOutput("midRstRData", rspRData, 32'h0);
        checkOutput("midRstErr", {30'b0, rspError, rspAbort}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Recovery after reset.
        applyStimulus(1'b1, 32'h60, 32'h12345678, 1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h64, 32'h0, 1, 32'h164, 1'b0, 1'b0);
        idleCmd();
        repeat (6) @(negedge clk);

        checkOutput("pendingRsp", 32'(expQ.size()), 32'h0);
        checkOutput("busCount", 32'(busLog.size()), 32'd14);
        for (int i = 0; i < 14 && i < busLog.size(); i++) begin
            checkOutput("busAddr", busLog[i], expBus[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
